// File: rtl/bios_load_pkg.sv
// bios_load_pkg: shared types and constants for the BIOS load controller.
//   bl_state_t : controller FSM states
//   BLK_AW     : address width of the default 64-word block buffer
package bios_load_pkg;

    typedef enum logic [1:0] {
        ROM_FILL = 2'd0,
        HPS_FILL = 2'd1,
        DRAIN    = 2'd2,
        DONE     = 2'd3
    } bl_state_t;

    localparam int BLK_WORDS_DEF = 64;
    localparam int BLK_AW        = $clog2(BLK_WORDS_DEF);

endpackage

// File: rtl/bios_blk_buf.sv
// bios_blk_buf: DEPTH x 16 simple dual-port RAM used to stage one block.
//   clk          : clock
//   we/waddr/wdata : write port
//   re/raddr     : read request; rdata updates one cycle later
//   rdata        : registered read data, holds its value while re=0
module bios_blk_buf #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [15:0]       wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [15:0]       rdata
);

    logic [15:0] mem_q [DEPTH];
    logic [15:0] rdata_q;

    // rdata holds while re=0 so the controller can use it as a prefetch stage.
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
        if (re) rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/bios_load_ctrl.sv
// bios_load_ctrl: moves a BIOS image (boot ROM copy, or HPS download override)
// through a block buffer into the system BIOS port, holding the CPU in reset
// until the whole image is in place.
//   ioctl_*       : HPS download stream; ioctl_wait backpressures it
//   rom_addr/rd   : boot ROM read port, rom_data valid one cycle after rom_rd
//   bios_addr/din : word presented to the system
//   bios_wr/req   : bios_wr=1 means {bios_addr,bios_din} is valid; the word is
//                   consumed in every cycle where bios_wr=1 and bios_req=1, and
//                   bios_req while bios_wr=0 has no effect
//   bios_loaded   : image complete; cpu_reset follows it one cycle later
//   dbg_state     : current FSM state
module bios_load_ctrl
    import bios_load_pkg::*;
#(
    parameter int AW         = 13,
    parameter int LOAD_WORDS = 4096,
    parameter int BLK_WORDS  = 1 << BLK_AW
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ioctl_download,
    input  logic          ioctl_wr,
    input  logic [24:0]   ioctl_addr,
    input  logic [15:0]   ioctl_dout,
    output logic          ioctl_wait,
    output logic [AW-1:0] rom_addr,
    output logic          rom_rd,
    input  logic [15:0]   rom_data,
    output logic [AW-1:0] bios_addr,
    output logic [15:0]   bios_din,
    output logic          bios_wr,
    input  logic          bios_req,
    output logic          bios_loaded,
    output logic          cpu_reset,
    output bl_state_t     dbg_state
);

    localparam int PTR_W = $clog2(BLK_WORDS);
    localparam int CNT_W = PTR_W + 1;
    localparam int SRC_W = $clog2(LOAD_WORDS + 1);

    bl_state_t        state_q, state_d;
    logic             dl_q;
    logic             hps_src_q, hps_src_d;
    logic [SRC_W-1:0] src_q, src_d;       // ROM words requested so far
    logic [CNT_W-1:0] cnt_q, cnt_d;       // words held in the buffer
    logic             rd_pend_q, rd_pend_d;
    logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d; // next buffer slot to read
    logic             pf_v_q, pf_v_d;     // buffer rdata holds an unsent word
    logic             wr_q, wr_d;
    logic [15:0]      din_q, din_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             cpu_reset_q, cpu_reset_d;

    logic             dl_rise, consume, stage_free, move, rom_rd_c;
    logic             buf_we, buf_re;
    logic [PTR_W-1:0] buf_waddr, buf_raddr;
    logic [15:0]      buf_wdata, buf_rdata;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^{ioctl_addr[24:PTR_W+1], ioctl_addr[0]};

    always_comb begin
        dl_rise     = ioctl_download & ~dl_q;
        consume     = wr_q & bios_req;
        state_d     = state_q;
        hps_src_d   = hps_src_q;
        src_d       = src_q;
        cnt_d       = cnt_q;
        rd_pend_d   = 1'b0;
        rd_ptr_d    = rd_ptr_q;
        pf_v_d      = pf_v_q;
        wr_d        = wr_q;
        din_d       = din_q;
        addr_d      = addr_q;
        buf_we      = 1'b0;
        buf_waddr   = cnt_q[PTR_W-1:0];
        buf_wdata   = rom_data;
        buf_re      = 1'b0;
        buf_raddr   = rd_ptr_q[PTR_W-1:0];
        rom_rd_c    = 1'b0;
        stage_free  = 1'b0;
        move        = 1'b0;

        case (state_q)
            ROM_FILL: begin
                rd_ptr_d = '0;
                pf_v_d   = 1'b0;
                if (rd_pend_q) begin
                    buf_we = 1'b1;
                    cnt_d  = cnt_q + CNT_W'(1);
                end
                // Reads in flight count against the block so it never overfills.
                rom_rd_c = ~dl_rise && (src_q < SRC_W'(LOAD_WORDS)) &&
                           ((cnt_q + CNT_W'(rd_pend_q)) < CNT_W'(BLK_WORDS));
                if (rom_rd_c) begin
                    src_d     = src_q + SRC_W'(1);
                    rd_pend_d = 1'b1;
                end
                // src_q at LOAD_WORDS with a read pending: that is the last word.
                if (rd_pend_q && (cnt_d == CNT_W'(BLK_WORDS) ||
                                  src_q == SRC_W'(LOAD_WORDS)))
                    state_d = DRAIN;
            end
            HPS_FILL: begin
                rd_ptr_d = '0;
                pf_v_d   = 1'b0;
                if (ioctl_wr) begin
                    buf_we    = 1'b1;
                    buf_waddr = ioctl_addr[PTR_W:1];
                    buf_wdata = ioctl_dout;
                    cnt_d     = cnt_q + CNT_W'(1);
                end
                if (cnt_d == CNT_W'(BLK_WORDS))
                    state_d = DRAIN;
                else if (!ioctl_download)
                    state_d = (cnt_d != '0) ? DRAIN : DONE;
            end
            DRAIN: begin
                // Two-stage pipe: buffer rdata (prefetch) -> din_q/wr_q (output).
                stage_free = ~wr_q | consume;
                if (consume) begin
                    addr_d = addr_q + AW'(1);
                    wr_d   = 1'b0;
                end
                if (pf_v_q && stage_free) begin
                    move  = 1'b1;
                    din_d = buf_rdata;
                    wr_d  = 1'b1;
                end
                // Only read when the prefetch slot is empty or emptying.
                buf_re = (rd_ptr_q != cnt_q) && (~pf_v_q || move);
                if (buf_re) begin
                    rd_ptr_d = rd_ptr_q + CNT_W'(1);
                    pf_v_d   = 1'b1;
                end else if (move) begin
                    pf_v_d = 1'b0;
                end
                if (consume && !pf_v_q && rd_ptr_q == cnt_q) begin
                    cnt_d = '0;
                    if (hps_src_q)
                        state_d = ioctl_download ? HPS_FILL : DONE;
                    else
                        state_d = (src_q == SRC_W'(LOAD_WORDS)) ? DONE : ROM_FILL;
                end
            end
            default: begin
                rd_ptr_d = '0;
                pf_v_d   = 1'b0;
            end
        endcase

        // A new download aborts whatever is in progress, including a consume.
        if (dl_rise) begin
            state_d   = HPS_FILL;
            hps_src_d = 1'b1;
            cnt_d     = '0;
            addr_d    = '0;
            wr_d      = 1'b0;
            rd_pend_d = 1'b0;
            rd_ptr_d  = '0;
            pf_v_d    = 1'b0;
            buf_we    = 1'b0;
        end

        cpu_reset_d = reset | (state_q != DONE);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= ROM_FILL;
            dl_q        <= 1'b0;
            hps_src_q   <= 1'b0;
            src_q       <= '0;
            cnt_q       <= '0;
            rd_pend_q   <= 1'b0;
            rd_ptr_q    <= '0;
            pf_v_q      <= 1'b0;
            wr_q        <= 1'b0;
            din_q       <= '0;
            addr_q      <= '0;
            cpu_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            dl_q        <= ioctl_download;
            hps_src_q   <= hps_src_d;
            src_q       <= src_d;
            cnt_q       <= cnt_d;
            rd_pend_q   <= rd_pend_d;
            rd_ptr_q    <= rd_ptr_d;
            pf_v_q      <= pf_v_d;
            wr_q        <= wr_d;
            din_q       <= din_d;
            addr_q      <= addr_d;
            cpu_reset_q <= cpu_reset_d;
        end
    end

    bios_blk_buf #(.DEPTH(BLK_WORDS), .ADDR_W(PTR_W)) u_buf (
        .clk   (clk_sys),
        .we    (buf_we),
        .waddr (buf_waddr),
        .wdata (buf_wdata),
        .re    (buf_re),
        .raddr (buf_raddr),
        .rdata (buf_rdata)
    );

    assign ioctl_wait  = ~reset & (state_q == DRAIN);
    assign rom_rd      = ~reset & rom_rd_c;
    assign rom_addr    = AW'(src_q);
    assign bios_addr   = addr_q;
    assign bios_din    = din_q;
    assign bios_wr     = wr_q;
    assign bios_loaded = ~reset & (state_q == DONE);
    assign cpu_reset   = cpu_reset_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_bios_load_ctrl.sv
module tb_bios_load_ctrl;
  import bios_load_pkg::*;

  localparam int AW = 13;
  localparam int EW = AW + 16;
  localparam int LOAD = 4096;

  logic          clk;
  logic          reset;
  logic          ioctl_download;
  logic          ioctl_wr;
  logic [24:0]   ioctl_addr;
  logic [15:0]   ioctl_dout;
  logic          ioctl_wait;
  logic [AW-1:0] rom_addr;
  logic          rom_rd;
  logic [15:0]   rom_data;
  logic [AW-1:0] bios_addr;
  logic [15:0]   bios_din;
  logic          bios_wr;
  logic          bios_req;
  logic          bios_loaded;
  logic          cpu_reset;
  bl_state_t     dbg_state;

  bios_load_ctrl #(.AW(AW), .LOAD_WORDS(LOAD), .BLK_WORDS(64)) dut (
    .clk_sys(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .rom_addr(rom_addr), .rom_rd(rom_rd), .rom_data(rom_data), .bios_addr(bios_addr),
    .bios_din(bios_din), .bios_wr(bios_wr), .bios_req(bios_req), .bios_loaded(bios_loaded),
    .cpu_reset(cpu_reset), .dbg_state(dbg_state)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ROM model: data = addr ^ 16'hA5A5, one cycle read latency
  always @(posedge clk) if (rom_rd) rom_data <= {3'b000, rom_addr} ^ 16'hA5A5;

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_err = 0;
  int req_mode = 0;   // 0: always 1, 1: random 50%
  bit run_chk = 0;
  int run_len = 0;
  int wr_cycles = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // bios_req driver
  initial begin
    bios_req = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bios_req = (req_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // consumer monitor
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (bios_wr) wr_cycles++;
    if (!reset && bios_wr && bios_req) begin
      if (exp_q.size() == 0) begin
        check("extra_word", {3'b000, bios_addr, bios_din}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("word", {3'b000, bios_addr, bios_din}, {3'b000, e});
      end
    end
    if (run_chk) begin
      if (bios_wr) run_len++;
      else if (run_len != 0) begin
        check("burst_len", run_len, 64);
        run_len = 0;
      end
    end
  end

  // driver tasks
  task automatic push_rom();
    for (int i = 0; i < LOAD; i++) exp_q.push_back({AW'(i), 16'(i) ^ 16'hA5A5});
  endtask

  task automatic hps_word(input int idx, input logic [15:0] d);
    int n = 0;
    while (ioctl_wait && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) check("hps_wait_timeout", 1, 0);
    ioctl_addr = 25'(idx * 2);
    ioctl_dout = d;
    ioctl_wr = 1'b1;
    exp_q.push_back({AW'(idx), d});
    @(negedge clk);
    ioctl_wr = 1'b0;
  endtask

  task automatic wait_loaded(input string name, input int max_cyc);
    int n = 0;
    while (!bios_loaded && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check({name, "_loaded"}, bios_loaded, 1);
    check({name, "_cpu_reset_hi"}, cpu_reset, 1);
    @(negedge clk);
    check({name, "_cpu_reset_lo"}, cpu_reset, 0);
  endtask

  // vector table: drive reset for some cycles, then expect these outputs
  typedef struct {
    logic          rst;
    int            cycles;
    logic          e_wait;
    logic          e_rom_rd;
    logic          e_wr;
    logic          e_loaded;
    logic          e_cpu;
    logic [AW-1:0] e_addr;
    logic [15:0]   e_din;
    bl_state_t     e_state;
  } vec_t;
  vec_t vecs[3];

  task automatic apply_row(input int i);
    string p;
    p = $sformatf("row%0d_", i);
    reset = vecs[i].rst;
    repeat (vecs[i].cycles) @(posedge clk);
    @(negedge clk);
    check({p, "wait"}, ioctl_wait, vecs[i].e_wait);
    check({p, "rom_rd"}, rom_rd, vecs[i].e_rom_rd);
    check({p, "bios_wr"}, bios_wr, vecs[i].e_wr);
    check({p, "loaded"}, bios_loaded, vecs[i].e_loaded);
    check({p, "cpu_reset"}, cpu_reset, vecs[i].e_cpu);
    check({p, "addr"}, bios_addr, vecs[i].e_addr);
    check({p, "din"}, bios_din, vecs[i].e_din);
    check({p, "state"}, 32'(dbg_state), 32'(vecs[i].e_state));
  endtask

  initial begin
    int n;
    int wr_before;
    logic [15:0] d;

    vecs[0] = '{rst: 1'b1, cycles: 4, e_wait: 1'b0, e_rom_rd: 1'b0, e_wr: 1'b0, e_loaded: 1'b0,
                e_cpu: 1'b1, e_addr: '0, e_din: '0, e_state: ROM_FILL};
    vecs[1] = '{rst: 1'b0, cycles: 1, e_wait: 1'b0, e_rom_rd: 1'b1, e_wr: 1'b0, e_loaded: 1'b0,
                e_cpu: 1'b1, e_addr: '0, e_din: '0, e_state: ROM_FILL};
    vecs[2] = '{rst: 1'b1, cycles: 1, e_wait: 1'b0, e_rom_rd: 1'b0, e_wr: 1'b0, e_loaded: 1'b0,
                e_cpu: 1'b1, e_addr: '0, e_din: '0, e_state: ROM_FILL};

    reset = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    @(negedge clk);

    // Boot ROM copy, bios_req held high: 64-word bursts with no gaps
    apply_row(0);
    push_rom();
    req_mode = 0;
    run_chk = 1;
    apply_row(1);
    wait_loaded("rom_cont", 20000);
    check("rom_cont_q_empty", exp_q.size(), 0);
    check("rom_cont_end_addr", bios_addr, 13'd4096);
    run_chk = 0;
    run_len = 0;

    // Boot ROM copy, random bios_req
    apply_row(0);
    exp_q.delete();
    push_rom();
    req_mode = 1;
    apply_row(1);
    wait_loaded("rom_rand", 30000);
    check("rom_rand_q_empty", exp_q.size(), 0);

    // Download of 100 words that aborts the ROM copy mid-fill
    apply_row(0);
    exp_q.delete();
    push_rom();
    apply_row(1);
    n = 0;
    while (!(bios_addr >= 13'd200 && dbg_state == ROM_FILL) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("abort_reach_fill", 32'(dbg_state), 32'(ROM_FILL));
    exp_q.delete();
    ioctl_download = 1'b1;
    @(negedge clk);
    check("abort_state", 32'(dbg_state), 32'(HPS_FILL));
    check("abort_addr", bios_addr, 0);
    check("abort_loaded", bios_loaded, 0);
    check("abort_cpu_reset", cpu_reset, 1);
    for (int i = 0; i < 100; i++) begin
      d = 16'($urandom_range(0, 16'hDEAC));
      hps_word(i, d);
      if (i == 63) begin
        // write while backpressured must be dropped
        check("wait_after_block", ioctl_wait, 1);
        ioctl_addr = 25'(5 * 2);
        ioctl_dout = 16'hDEAD;
        ioctl_wr = 1'b1;
        @(negedge clk);
        ioctl_wr = 1'b0;
      end
    end
    ioctl_download = 1'b0;
    wait_loaded("hps", 2000);
    check("hps_q_empty", exp_q.size(), 0);
    check("hps_end_addr", bios_addr, 100);

    // Empty download: no words, straight to DONE, no bios_wr
    wr_before = wr_cycles;
    ioctl_download = 1'b1;
    repeat (3) @(negedge clk);
    check("empty_state", 32'(dbg_state), 32'(HPS_FILL));
    check("empty_loaded_low", bios_loaded, 0);
    ioctl_download = 1'b0;
    wait_loaded("empty", 100);
    check("empty_no_wr", wr_cycles - wr_before, 0);
    check("empty_addr", bios_addr, 0);

    // Reset in the middle of a drain, then a full restart
    apply_row(0);
    exp_q.delete();
    push_rom();
    req_mode = 0;
    apply_row(1);
    n = 0;
    while (!(bios_addr == 13'd30 && bios_wr) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("mid_drain_reached", bios_addr, 30);
    @(posedge clk);
    #2;
    apply_row(2);
    exp_q.delete();
    push_rom();
    apply_row(1);
    wait_loaded("restart", 20000);
    check("restart_q_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
